// File: rtl/mux_sel_reg.sv
// Registered N-way source selector with fixed or round-robin grant.
// Output register sits behind a valid/ready handshake.
module mux_sel_reg #(
   parameter int WIDTH = 32,
   parameter int N     = 8,
   parameter int SELW  = $clog2(N)
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    select,
   input  logic               mode,
   output logic [WIDTH-1:0]   out_data,
   output logic [SELW-1:0]    out_sel,
   output logic               out_valid,
   input  logic               out_ready
);

   localparam logic [SELW:0] LP_N = (SELW+1)'(N);

   logic [WIDTH-1:0] r_data;
   logic [SELW-1:0]  r_sel;
   logic             r_valid;
   logic [SELW-1:0]  r_ptr;

   logic             w_accept;
   logic             w_xfer;
   logic             w_fix_vld;
   logic             w_rr_vld;
   logic             w_gnt_vld;
   logic [SELW-1:0]  w_fix;
   logic [SELW-1:0]  w_off;
   logic [SELW-1:0]  w_rr;
   logic [SELW-1:0]  w_gnt;
   logic [SELW:0]    w_sum;
   logic [N-1:0]     w_rot;
   logic [WIDTH-1:0] w_data;

   assign w_accept = !r_valid || out_ready;

   // Compare against every legal index so codes >= N never grant.
   always_comb begin
      w_fix_vld = 1'b0;
      w_fix     = select;
      for (int i = 0; i < N; i++) begin
         if (select == SELW'(i) && in_valid[i])
            w_fix_vld = 1'b1;
      end
   end

   // Rotate valids so bit k is source (ptr+k) mod N.
   assign w_rot = N'({in_valid, in_valid} >> r_ptr);

   always_comb begin
      w_rr_vld = 1'b0;
      w_off    = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[k]) begin
            w_rr_vld = 1'b1;
            w_off    = SELW'(k);
         end
      end
   end

   assign w_sum = {1'b0, r_ptr} + {1'b0, w_off};
   assign w_rr  = (w_sum >= LP_N) ? SELW'(w_sum - LP_N)
                                  : w_sum[SELW-1:0];

   assign w_gnt_vld = mode ? w_rr_vld : w_fix_vld;
   assign w_gnt     = mode ? w_rr : w_fix;
   assign w_xfer    = resetn && w_accept && w_gnt_vld;

   always_comb begin
      w_data   = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (w_gnt == SELW'(i)) begin
            w_data      = in_data[i*WIDTH +: WIDTH];
            in_ready[i] = w_xfer;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_data  <= '0;
         r_sel   <= '0;
         r_valid <= 1'b0;
         r_ptr   <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= w_gnt_vld;
            if (w_gnt_vld) begin
               r_data <= w_data;
               r_sel  <= w_gnt;
            end
         end
         if (w_xfer && mode) begin
            if (w_gnt == SELW'(N - 1))
               r_ptr <= '0;
            else
               r_ptr <= w_gnt + 1'b1;
         end
      end
   end

   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign out_valid = r_valid;

endmodule

// File: tb/tb_mux_sel_reg.sv
// Random and directed checks of mux_sel_reg (N=8 and N=6)
// against a behavioural selector model.
module tb_mux_sel_reg;

   logic         clock;
   logic         resetn;
   logic [255:0] in_data;
   logic [7:0]   vin;
   logic [2:0]   select;
   logic         mode;
   logic         out_ready;
   logic [31:0]  src [8];

   logic [7:0]   in_ready8;
   logic [31:0]  out_data8;
   logic [2:0]   out_sel8;
   logic         out_valid8;

   logic [5:0]   in_ready6;
   logic [31:0]  out_data6;
   logic [2:0]   out_sel6;
   logic         out_valid6;

   int n_err = 0;
   int n_chk = 0;

   int          m_ptr [2];
   int          m_sel [2];
   bit          m_vld [2];
   logic [31:0] m_dat [2];

   mux_sel_reg #(.WIDTH(32), .N(8)) dut8 (
      .clock(clock), .resetn(resetn),
      .in_data(in_data), .in_valid(vin),
      .in_ready(in_ready8), .select(select),
      .mode(mode), .out_data(out_data8),
      .out_sel(out_sel8), .out_valid(out_valid8),
      .out_ready(out_ready)
   );

   mux_sel_reg #(.WIDTH(32), .N(6)) dut6 (
      .clock(clock), .resetn(resetn),
      .in_data(in_data[191:0]), .in_valid(vin[5:0]),
      .in_ready(in_ready6), .select(select),
      .mode(mode), .out_data(out_data6),
      .out_sel(out_sel6), .out_valid(out_valid6),
      .out_ready(out_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always_comb begin
      in_data = '0;
      for (int i = 0; i < 8; i++)
         in_data[i*32 +: 32] = src[i];
   end

   task automatic check(string tag, logic [63:0] got,
                        logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] obs(int u, int w);
      logic [63:0] v;
      v = '0;
      case (w)
         0: v = u ? 64'(in_ready6)  : 64'(in_ready8);
         1: v = u ? 64'(out_valid6) : 64'(out_valid8);
         2: v = u ? 64'(out_sel6)   : 64'(out_sel8);
         default: v = u ? 64'(out_data6) : 64'(out_data8);
      endcase
      return v;
   endfunction

   function automatic int nsrc(int u);
      return u ? 6 : 8;
   endfunction

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         m_ptr[u] = 0; m_sel[u] = 0;
         m_vld[u] = 0; m_dat[u] = '0;
      end
   endfunction

   // First valid source in search order, or the select code if legal.
   function automatic void grant(int u, output bit gv,
                                 output int g);
      int n;
      int i;
      n = nsrc(u);
      gv = 0;
      g = 0;
      if (!mode) begin
         if (int'(select) < n && vin[select]) begin
            gv = 1;
            g = int'(select);
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            i = (m_ptr[u] + k) % n;
            if (!gv && vin[i]) begin
               gv = 1;
               g = i;
            end
         end
      end
   endfunction

   task automatic check_outs();
      for (int u = 0; u < 2; u++) begin
         check($sformatf("vld%0d", nsrc(u)), obs(u, 1),
               64'(m_vld[u]));
         check($sformatf("sel%0d", nsrc(u)), obs(u, 2),
               64'(m_sel[u]));
         check($sformatf("dat%0d", nsrc(u)), obs(u, 3),
               64'(m_dat[u]));
      end
   endtask

   task automatic cycle();
      bit gv [2];
      int g [2];
      bit acc [2];
      logic [63:0] exp;
      #1;
      for (int u = 0; u < 2; u++) begin
         grant(u, gv[u], g[u]);
         acc[u] = !m_vld[u] || out_ready;
         exp = (acc[u] && gv[u]) ? (64'd1 << g[u]) : 64'd0;
         check($sformatf("rdy%0d", nsrc(u)), obs(u, 0), exp);
      end
      @(posedge clock);
      for (int u = 0; u < 2; u++) begin
         if (acc[u]) begin
            if (gv[u]) begin
               m_dat[u] = src[g[u]];
               m_sel[u] = g[u];
               m_vld[u] = 1;
               if (mode) m_ptr[u] = (g[u] + 1) % nsrc(u);
            end else begin
               m_vld[u] = 0;
            end
         end
      end
      #1;
      check_outs();
   endtask

   initial begin
      resetn = 1'b0;
      mode = 1'b0;
      select = '0;
      out_ready = 1'b1;
      vin = 8'hFF;
      for (int i = 0; i < 8; i++) src[i] = 32'h1000_0000 + i;
      model_reset();
      #3;
      check_outs();
      check("rst_rdy8", 64'(in_ready8), 64'd0);
      check("rst_rdy6", 64'(in_ready6), 64'd0);
      @(posedge clock);
      #1 resetn = 1'b1;

      // Fixed select stepping
      for (int s = 0; s < 8; s++) begin
         select = 3'(s);
         cycle();
         check("seq_data", 64'(out_data8),
               64'(32'h1000_0000 + s));
         check("seq_sel", 64'(out_sel8), 64'(s));
      end

      // Round-robin over all sources, then 2 and 5 only
      mode = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("rr_sel", 64'(out_sel8), 64'(k % 8));
      end
      vin = 8'b0010_0100;
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("rr25_sel", 64'(out_sel8), (k % 2) ? 64'd5 : 64'd2);
      end

      // Backpressure, then drain and refill together
      vin = 8'hFF;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) cycle();
      out_ready = 1'b1;
      cycle();
      cycle();

      // Out-of-range select on N=6, and an invalid source
      mode = 1'b0;
      select = 3'd7;
      cycle();
      cycle();
      select = 3'd3;
      vin = 8'b1111_0111;
      cycle();
      cycle();

      // Park ptr at 4, detour through fixed mode, resume
      mode = 1'b1;
      vin = 8'b0000_1000;
      cycle();
      mode = 1'b0;
      select = 3'd1;
      vin = 8'hFF;
      cycle();
      cycle();
      mode = 1'b1;
      cycle();
      check("resume_sel", 64'(out_sel8), 64'd4);

      // Asynchronous reset between edges
      cycle();
      #2 resetn = 1'b0;
      model_reset();
      #1;
      check_outs();
      check("arst_rdy8", 64'(in_ready8), 64'd0);
      @(posedge clock);
      #1 resetn = 1'b1;
      cycle();
      check("post_rst_sel", 64'(out_sel8), 64'd0);

      // Random traffic
      for (int k = 0; k < 500; k++) begin
         vin = 8'($urandom);
         mode = 1'($urandom);
         select = 3'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         src[$urandom_range(0, 7)] = $urandom;
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
